// File: rtl/prog_loader_if.sv
// Byte-stream / instruction-memory bundle between the boot loader and its neighbours.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready; with byte_valid low nothing happens.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  load_done;
    logic                  load_error;
    logic [2:0]            state_dbg;

    // master = byte source / observer side, slave = the loader
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, load_done, load_error, state_dbg
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, load_done, load_error, state_dbg
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed little-endian byte image into instruction memory,
// verifies an XOR checksum and only then releases the processor from reset.
module prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    state_t                state_q;
    logic [15:0]           n_q;
    logic [7:0]            xor_q;
    logic [31:0]           word_q;
    logic [1:0]            bcnt_q;
    logic [ADDR_WIDTH:0]   idx_q;

    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  cpu_rst_q;
    logic                  done_q;
    logic                  err_q;

    logic                  acc;
    logic [7:0]            xor_d;
    logic [31:0]           word_d;
    logic [15:0]           n_d;
    logic [ADDR_WIDTH:0]   idx_d;

    assign acc    = bus.byte_valid && ready_q;
    assign xor_d  = xor_q ^ bus.byte_data;
    assign word_d = {bus.byte_data, word_q[31:8]};
    assign n_d    = {bus.byte_data, n_q[7:0]};
    assign idx_d  = idx_q + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HDR0;
            n_q       <= '0;
            xor_q     <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            ready_q <= (state_q != S_DONE) && (state_q != S_ERR);
            if (acc) begin
                case (state_q)
                    S_HDR0: begin
                        n_q[7:0] <= bus.byte_data;
                        xor_q    <= xor_d;
                        state_q  <= S_HDR1;
                    end
                    S_HDR1: begin
                        n_q   <= n_d;
                        xor_q <= xor_d;
                        if (32'(n_d) > MAX_WORDS) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (n_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        xor_q  <= xor_d;
                        word_q <= word_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        // Fourth byte completes the word; strobe it out next cycle.
                        if (bcnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= idx_q[ADDR_WIDTH-1:0];
                            wdata_q <= word_d;
                            idx_q   <= idx_d;
                            if (32'(idx_d) == 32'(n_q)) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        ready_q <= 1'b0;
                        if (bus.byte_data == xor_q) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = cpu_rst_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded imem writes plus end-of-load status checks.
module tb_prog_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;

    prog_loader_if #(.ADDR_WIDTH(AW)) bus();

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     stim_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_we", {32'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
            end else begin
                check_val("imem_write", {24'd0, bus.imem_addr, bus.imem_wdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (bus.byte_ready !== 1'b1) begin
            check_val("ready_timeout", 64'd0, 64'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic run_stream(input int gap_max);
        foreach (stim_q[i]) begin
            if (gap_max > 0) idle($urandom_range(1, gap_max));
            send_byte(stim_q[i]);
        end
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ready"}, bus.byte_ready, 0);
        check_val({tag, "_we"},    bus.imem_we, 0);
        check_val({tag, "_addr"},  bus.imem_addr, 0);
        check_val({tag, "_wdata"}, bus.imem_wdata, 0);
        check_val({tag, "_cpurst"},bus.cpu_reset, 1);
        check_val({tag, "_done"},  bus.load_done, 0);
        check_val({tag, "_err"},   bus.load_error, 0);
    endtask

    task automatic check_end(input string tag, input logic done);
        check_val({tag, "_done"},   bus.load_done, done);
        check_val({tag, "_err"},    bus.load_error, !done);
        check_val({tag, "_cpurst"}, bus.cpu_reset, !done);
        check_val({tag, "_ready"},  bus.byte_ready, 0);
        check_val({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic two_word_stream();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h50, 8'h00, 8'hD2};
    endtask

    task automatic push_two_word_writes();
        exp_q.push_back({8'h00, 32'h0000_0013});
        exp_q.push_back({8'h01, 32'h0050_0093});
    endtask

    task automatic make_image(input int n, input bit bad);
        logic [7:0]  cs;
        logic [31:0] w;
        stim_q = {};
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) stim_q.push_back(8'(w >> (8 * k)));
            exp_q.push_back({8'(i), w});
        end
        cs = 8'h00;
        foreach (stim_q[i]) cs = cs ^ stim_q[i];
        stim_q.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    initial begin
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready_after", bus.byte_ready, 1);
        check_val("rst_state_dbg", bus.state_dbg, 0);

        // Two-word image, back-to-back bytes
        two_word_stream();
        push_two_word_writes();
        run_stream(0);
        check_end("two_word", 1'b1);

        // Same image with random idle gaps
        do_reset();
        two_word_stream();
        push_two_word_writes();
        run_stream(5);
        check_end("gaps", 1'b1);

        // Bad checksum: writes still happen, then error; later bytes ignored
        do_reset();
        two_word_stream();
        stim_q[10] = 8'hD3;
        push_two_word_writes();
        run_stream(0);
        check_end("bad_csum", 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h13;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        check_val("bad_csum_sticky", bus.load_error, 1);
        check_val("bad_csum_ready", bus.byte_ready, 0);

        // Oversize header N = 257
        do_reset();
        stim_q = '{8'h01, 8'h01};
        run_stream(0);
        check_end("oversize", 1'b0);

        // Full memory N = 256
        do_reset();
        make_image(256, 1'b0);
        run_stream(0);
        check_end("full", 1'b1);

        // Zero-word image
        do_reset();
        stim_q = '{8'h00, 8'h00, 8'h00};
        run_stream(0);
        check_end("zero", 1'b1);

        // Reset after six bytes, then replay
        do_reset();
        two_word_stream();
        exp_q.push_back({8'h00, 32'h0000_0013});
        for (int i = 0; i < 6; i++) send_byte(stim_q[i]);
        @(negedge clk);
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_ready_after", bus.byte_ready, 1);
        push_two_word_writes();
        run_stream(0);
        check_end("replay", 1'b1);

        // Random image with gaps
        do_reset();
        make_image($urandom_range(1, 6), 1'b0);
        run_stream(3);
        check_end("rand", 1'b1);

        idle(3);
        check_val("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
